// File: rtl/id_pkg.sv
// Shared RV32I decode definitions: opcode constants, opcode classes, control bundle, immediate generator.
package id_pkg;

    localparam int INST_W   = 32;
    localparam int OPCLS_W  = 4;
    localparam int FUNCT3_W = 3;
    localparam int REG_W    = 5;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST    = 7'b0100011;
    localparam logic [6:0] OPC_OPI   = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    typedef enum logic [OPCLS_W-1:0] {
        CLS_LUI   = 4'd0,
        CLS_AUIPC = 4'd1,
        CLS_JAL   = 4'd2,
        CLS_JALR  = 4'd3,
        CLS_BR    = 4'd4,
        CLS_LD    = 4'd5,
        CLS_ST    = 4'd6,
        CLS_OPI   = 4'd7,
        CLS_OP    = 4'd8,
        CLS_ILL   = 4'd15
    } opcls_t;

    typedef struct packed {
        opcls_t                opcls;
        logic [FUNCT3_W-1:0]   funct3;
        logic                  f7b5;
        logic                  we;
        logic                  illegal;
    } ctl_t;

    function automatic opcls_t decode_cls(input logic [6:0] opc);
        opcls_t c;
        case (opc)
            OPC_LUI:   c = CLS_LUI;
            OPC_AUIPC: c = CLS_AUIPC;
            OPC_JAL:   c = CLS_JAL;
            OPC_JALR:  c = CLS_JALR;
            OPC_BR:    c = CLS_BR;
            OPC_LD:    c = CLS_LD;
            OPC_ST:    c = CLS_ST;
            OPC_OPI:   c = CLS_OPI;
            OPC_OP:    c = CLS_OP;
            default:   c = CLS_ILL;
        endcase
        return c;
    endfunction

    function automatic logic reads_rs1(input opcls_t c);
        return !(c inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_ILL});
    endfunction

    function automatic logic reads_rs2(input opcls_t c);
        return c inside {CLS_BR, CLS_ST, CLS_OP};
    endfunction

    function automatic logic writes_rd(input opcls_t c);
        return c inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LD, CLS_OPI, CLS_OP};
    endfunction

    // Shift-immediates (funct3 001/101) carry only a 5-bit shamt; funct7 must not leak into imm.
    function automatic logic [31:0] imm_gen(input logic [31:7] i, input opcls_t c);
        logic [31:0] imm;
        imm = '0;
        case (c)
            CLS_LUI, CLS_AUIPC: imm = {i[31:12], 12'b0};
            CLS_JAL:            imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            CLS_BR:             imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            CLS_ST:             imm = {{21{i[31]}}, i[30:25], i[11:7]};
            CLS_JALR, CLS_LD:   imm = {{21{i[31]}}, i[30:20]};
            CLS_OPI: begin
                if (i[13:12] == 2'b01)
                    imm = {27'b0, i[24:20]};
                else
                    imm = {{21{i[31]}}, i[30:20]};
            end
            default:            imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Operand select: lowest-index forwarding source matching rs wins, else register file; x0 reads zero.
// Purely combinational, no backpressure.
module id_fwd_mux #(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5,
    parameter int FWD_PORTS = 2
) (
    input  logic [NREG_BITS-1:0]           rs,
    input  logic [XLEN-1:0]                rf_rdata,
    input  logic [FWD_PORTS-1:0]           fwd_we,
    input  logic [FWD_PORTS*NREG_BITS-1:0] fwd_waddr,
    input  logic [FWD_PORTS*XLEN-1:0]      fwd_wdata,
    output logic [XLEN-1:0]                val
);

    always_comb begin
        val = rf_rdata;
        // Walk oldest to nearest so the nearest match overwrites.
        for (int i = FWD_PORTS - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_waddr[i*NREG_BITS +: NREG_BITS] == rs))
                val = fwd_wdata[i*XLEN +: XLEN];
        end
        if (rs == '0)
            val = '0;
    end

endmodule

// File: rtl/id_stage_fwd.sv
// RV32I decode stage: IF/ID latch, decoder, operand forwarding, registered ID/EX bundle; 1 cycle capture-to-out.
// Holds on load-use hazard or out_ready=0; optional decode-time branch resolve under ID_BRANCH_RESOLVE_EN.
module id_stage_fwd
    import id_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5,
    parameter int FWD_PORTS = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [XLEN-1:0]                in_pc,
    input  logic [31:0]                    in_inst,
    output logic [NREG_BITS-1:0]           rf_raddr1,
    output logic [NREG_BITS-1:0]           rf_raddr2,
    input  logic [XLEN-1:0]                rf_rdata1,
    input  logic [XLEN-1:0]                rf_rdata2,
    input  logic [FWD_PORTS-1:0]           fwd_we,
    input  logic [FWD_PORTS*NREG_BITS-1:0] fwd_waddr,
    input  logic [FWD_PORTS*XLEN-1:0]      fwd_wdata,
    input  logic                           fwd0_is_load,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [XLEN-1:0]                out_pc,
    output logic [XLEN-1:0]                out_imm,
    output logic [XLEN-1:0]                out_rs1v,
    output logic [XLEN-1:0]                out_rs2v,
    output logic [3:0]                     out_opcls,
    output logic [2:0]                     out_funct3,
    output logic                           out_f7b5,
    output logic [NREG_BITS-1:0]           out_rd,
    output logic                           out_we,
    output logic                           out_illegal
`ifdef ID_BRANCH_RESOLVE_EN
    ,
    output logic                           redirect_valid,
    output logic [XLEN-1:0]                redirect_pc
`endif
);

    logic                 latch_valid;
    logic [XLEN-1:0]      latch_pc;
    logic [INST_W-1:0]    latch_inst;

    opcls_t               dec_cls;
    ctl_t                 dec_ctl;
    ctl_t                 out_ctl;
    logic [NREG_BITS-1:0] rs1, rs2, rd, ld_dst;
    logic                 re1, re2;
    logic [XLEN-1:0]      imm, rs1v, rs2v;
    logic                 hazard, advance;

    assign rs1    = NREG_BITS'(latch_inst[19:15]);
    assign rs2    = NREG_BITS'(latch_inst[24:20]);
    assign rd     = NREG_BITS'(latch_inst[11:7]);
    assign ld_dst = fwd_waddr[NREG_BITS-1:0];

    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;

    always_comb begin
        dec_cls         = decode_cls(latch_inst[6:0]);
        re1             = reads_rs1(dec_cls);
        re2             = reads_rs2(dec_cls);
        imm             = XLEN'($signed(imm_gen(latch_inst[31:7], dec_cls)));
        dec_ctl.opcls   = dec_cls;
        dec_ctl.funct3  = latch_inst[14:12];
        dec_ctl.f7b5    = latch_inst[30];
        dec_ctl.illegal = (dec_cls == CLS_ILL);
        dec_ctl.we      = writes_rd(dec_cls) && (rd != '0);
    end

    id_fwd_mux #(
        .XLEN      (XLEN),
        .NREG_BITS (NREG_BITS),
        .FWD_PORTS (FWD_PORTS)
    ) u_fwd_rs1 (
        .rs        (rs1),
        .rf_rdata  (rf_rdata1),
        .fwd_we    (fwd_we),
        .fwd_waddr (fwd_waddr),
        .fwd_wdata (fwd_wdata),
        .val       (rs1v)
    );

    id_fwd_mux #(
        .XLEN      (XLEN),
        .NREG_BITS (NREG_BITS),
        .FWD_PORTS (FWD_PORTS)
    ) u_fwd_rs2 (
        .rs        (rs2),
        .rf_rdata  (rf_rdata2),
        .fwd_we    (fwd_we),
        .fwd_waddr (fwd_waddr),
        .fwd_wdata (fwd_wdata),
        .val       (rs2v)
    );

    // Load in EX has no data yet: the consumer must wait in the latch.
    always_comb begin
        hazard = latch_valid && fwd0_is_load && fwd_we[0] &&
                 ((re1 && (rs1 != '0) && (rs1 == ld_dst)) ||
                  (re2 && (rs2 != '0) && (rs2 == ld_dst)));
        advance  = latch_valid && !hazard && (!out_valid || out_ready);
        in_ready = rdy && (!latch_valid || advance);
    end

`ifdef ID_BRANCH_RESOLVE_EN
    logic taken;

    always_comb begin
        taken = 1'b0;
        if (dec_cls == CLS_JAL) begin
            taken = 1'b1;
        end else if (dec_cls == CLS_BR) begin
            case (dec_ctl.funct3)
                3'b000:  taken = (rs1v == rs2v);
                3'b001:  taken = (rs1v != rs2v);
                3'b100:  taken = ($signed(rs1v) <  $signed(rs2v));
                3'b101:  taken = ($signed(rs1v) >= $signed(rs2v));
                3'b110:  taken = (rs1v <  rs2v);
                3'b111:  taken = (rs1v >= rs2v);
                default: taken = 1'b0;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_valid <= 1'b0;
            latch_pc    <= '0;
            latch_inst  <= '0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_imm     <= '0;
            out_rs1v    <= '0;
            out_rs2v    <= '0;
            out_rd      <= '0;
            out_ctl     <= '0;
`ifdef ID_BRANCH_RESOLVE_EN
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
`endif
        end else if (rdy) begin
`ifdef ID_BRANCH_RESOLVE_EN
            redirect_valid <= 1'b0;
`endif
            if (flush) begin
                latch_valid <= 1'b0;
                out_valid   <= 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    latch_valid <= 1'b1;
                    latch_pc    <= in_pc;
                    latch_inst  <= in_inst;
                end else if (advance) begin
                    latch_valid <= 1'b0;
                end
`ifdef ID_BRANCH_RESOLVE_EN
                // A taken jump/branch makes whatever fetch just handed us wrong-path.
                if (advance && taken) begin
                    latch_valid    <= 1'b0;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= latch_pc + imm;
                end
`endif
                if (advance) begin
                    out_valid <= 1'b1;
                    out_pc    <= latch_pc;
                    out_imm   <= imm;
                    out_rs1v  <= rs1v;
                    out_rs2v  <= rs2v;
                    out_rd    <= rd;
                    out_ctl   <= dec_ctl;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_opcls   = out_ctl.opcls;
    assign out_funct3  = out_ctl.funct3;
    assign out_f7b5    = out_ctl.f7b5;
    assign out_we      = out_ctl.we;
    assign out_illegal = out_ctl.illegal;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed bench for id_stage_fwd: expected bundles queued at acceptance, compared when EX takes them.
module tb_id_stage_fwd;
    import id_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, flush, in_valid, in_ready, out_ready, fwd0_is_load;
    logic [31:0] in_pc, in_inst, rf_rdata1, rf_rdata2;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_waddr;
    logic [63:0] fwd_wdata;
    logic        out_valid, out_f7b5, out_we, out_illegal;
    logic [31:0] out_pc, out_imm, out_rs1v, out_rs2v;
    logic [3:0]  out_opcls;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd;
`ifdef ID_BRANCH_RESOLVE_EN
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`endif

    // Register-file model: xN holds 0x1000+N.
    assign rf_rdata1 = 32'h1000 | {27'b0, rf_raddr1};
    assign rf_rdata2 = 32'h1000 | {27'b0, rf_raddr2};

    id_stage_fwd dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd0_is_load(fwd0_is_load),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1v(out_rs1v), .out_rs2v(out_rs2v), .out_opcls(out_opcls), .out_funct3(out_funct3),
        .out_f7b5(out_f7b5), .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
`ifdef ID_BRANCH_RESOLVE_EN
        , .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`endif
    );

    typedef struct packed {
        logic [31:0] pc, imm, rs1v, rs2v;
        opcls_t      cls;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rd;
        logic        we, ill, c1, c2;
    } exp_t;

    exp_t sbq[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic logic [31:0] rfv(input logic [4:0] r);
        return (r == 5'd0) ? 32'h0 : (32'h1000 | {27'b0, r});
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] imm,
                                input opcls_t cls, input logic we, input logic ill,
                                input logic [31:0] v1, input logic [31:0] v2, input logic c1, input logic c2);
        exp_t e;
        e.pc = pc;  e.imm = imm;  e.rs1v = v1;  e.rs2v = v2;
        e.cls = cls;  e.f3 = inst[14:12];  e.f7b5 = inst[30];  e.rd = inst[11:7];
        e.we = we;  e.ill = ill;  e.c1 = c1;  e.c2 = c2;
        return e;
    endfunction

    task automatic compare_bundle(input exp_t e);
        chk("pc", out_pc, e.pc);
        chk("imm", out_imm, e.imm);
        chk("opcls", {28'b0, out_opcls}, {28'b0, e.cls});
        chk("funct3", {29'b0, out_funct3}, {29'b0, e.f3});
        chk("f7b5", {31'b0, out_f7b5}, {31'b0, e.f7b5});
        chk("rd", {27'b0, out_rd}, {27'b0, e.rd});
        chk("we", {31'b0, out_we}, {31'b0, e.we});
        chk("illegal", {31'b0, out_illegal}, {31'b0, e.ill});
        if (e.c1) chk("rs1v", out_rs1v, e.rs1v);
        if (e.c2) chk("rs2v", out_rs2v, e.rs2v);
    endtask

    // One clock: observe handshakes mid-cycle, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) chk("spurious_out", {31'b0, out_valid}, 32'd0);
            else compare_bundle(sbq.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input exp_t e, input logic [31:0] inst);
        logic got;
        got      = 1'b0;
        in_pc    = e.pc;
        in_inst  = inst;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            got = last_acc;
        end
        in_valid = 1'b0;
        chk("accept", {31'b0, got}, 32'd1);
        if (got) sbq.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sbq.size() != 0; k++) tick();
        chk("drain_empty", sbq.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;  rdy = 1'b1;  flush = 1'b0;  in_valid = 1'b0;  in_pc = '0;  in_inst = '0;
        out_ready = 1'b1;  fwd_we = '0;  fwd_waddr = '0;  fwd_wdata = '0;  fwd0_is_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_imm", out_imm, 32'd0);
        chk("reset_out_rs1v", out_rs1v, 32'd0);
        chk("reset_out_we", {31'b0, out_we}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // ADDI x1,x0,-5
        send(mk(32'h100, 32'hFFB00093, 32'hFFFFFFFB, CLS_OPI, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0), 32'hFFB00093);
        drain();

        // Both sources hit x3: nearest (source 0) wins. ADD x4,x3,x3
        fwd_we = 2'b11;  fwd_waddr = {5'd3, 5'd3};  fwd_wdata = {32'hBB, 32'hAA};
        send(mk(32'h104, 32'h00318233, 32'h0, CLS_OP, 1'b1, 1'b0, 32'hAA, 32'hAA, 1'b1, 1'b1), 32'h00318233);
        drain();
        // Source 0 targets x0 (never forwarded), source 1 supplies x3. ADD x7,x0,x3
        fwd_waddr = {5'd3, 5'd0};
        send(mk(32'h108, 32'h003003B3, 32'h0, CLS_OP, 1'b1, 1'b0, 32'h0, 32'hBB, 1'b1, 1'b1), 32'h003003B3);
        drain();

        // Load-use on x5: ADD x6,x5,x1 holds until the load data arrives.
        fwd_we = 2'b01;  fwd_waddr = {5'd0, 5'd5};  fwd_wdata = {32'h0, 32'hDEAD};  fwd0_is_load = 1'b1;
        send(mk(32'h10C, 32'h00128333, 32'h0, CLS_OP, 1'b1, 1'b0, 32'h55, rfv(5'd1), 1'b1, 1'b1), 32'h00128333);
        chk("hazard_in_ready", {31'b0, in_ready}, 32'd0);
        chk("hazard_bubble", {31'b0, out_valid}, 32'd0);
        tick();
        chk("hazard_in_ready_hold", {31'b0, in_ready}, 32'd0);
        chk("hazard_bubble_hold", {31'b0, out_valid}, 32'd0);
        fwd0_is_load = 1'b0;  fwd_wdata = {32'h0, 32'h55};
        drain();
        fwd_we = '0;  fwd_waddr = '0;  fwd_wdata = '0;

        rdy = 1'b0;
        #1 chk("rdy0_in_ready", {31'b0, in_ready}, 32'd0);
        rdy = 1'b1;

        // Backpressure with two instructions in flight: ADDI x2,x0,7 then ADDI x3,x0,9
        out_ready = 1'b0;
        send(mk(32'h200, 32'h00700113, 32'd7, CLS_OPI, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0), 32'h00700113);
        send(mk(32'h204, 32'h00900193, 32'd9, CLS_OPI, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0), 32'h00900193);
        for (int k = 0; k < 3; k++) begin
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_out_pc", out_pc, 32'h200);
            chk("stall_out_imm", out_imm, 32'd7);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        drain();

        // Back-to-back decode patterns
        send(mk(32'h300, 32'h40335293, 32'd3, CLS_OPI, 1'b1, 1'b0, rfv(5'd6), 32'h0, 1'b1, 1'b0), 32'h40335293);
        send(mk(32'h304, 32'hFE20AE23, 32'hFFFFFFFC, CLS_ST, 1'b0, 1'b0, rfv(5'd1), rfv(5'd2), 1'b1, 1'b1), 32'hFE20AE23);
        send(mk(32'h308, 32'hFE208CE3, 32'hFFFFFFF8, CLS_BR, 1'b0, 1'b0, rfv(5'd1), rfv(5'd2), 1'b1, 1'b1), 32'hFE208CE3);
        send(mk(32'h30C, 32'h0104A403, 32'd16, CLS_LD, 1'b1, 1'b0, rfv(5'd9), 32'h0, 1'b1, 1'b0), 32'h0104A403);
        send(mk(32'h310, 32'h00001017, 32'h1000, CLS_AUIPC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 32'h00001017);
        send(mk(32'h314, 32'h0000057F, 32'h0, CLS_ILL, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0), 32'h0000057F);
        send(mk(32'h318, 32'h001000EF, 32'h800, CLS_JAL, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 32'h001000EF);
        drain();

        // Flush coincident with in_valid: the instruction must never emerge.
        in_pc = 32'h400;  in_inst = 32'h00700113;  in_valid = 1'b1;  flush = 1'b1;
        tick();
        in_valid = 1'b0;  flush = 1'b0;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_latch_empty", {31'b0, in_ready}, 32'd1);
        repeat (3) tick();
        chk("flush_no_emit", {31'b0, out_valid}, 32'd0);

        // Flush kills a bundle parked in the output register.
        out_ready = 1'b0;
        send(mk(32'h410, 32'h00700113, 32'd7, CLS_OPI, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0), 32'h00700113);
        tick();
        chk("parked_out_valid", {31'b0, out_valid}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        void'(sbq.pop_front());
        chk("flush_kill_out", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (2) tick();

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        send(mk(32'h500, 32'h00900193, 32'd9, CLS_OPI, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0), 32'h00900193);
        tick();
        chk("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_idle", {31'b0, out_valid}, 32'd0);
        end
        // LUI x10,0x12345
        send(mk(32'h600, 32'h12345537, 32'h12345000, CLS_LUI, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0), 32'h12345537);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
